mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STREAK_MAX, default 4: maximum consecutive data grants while an instruction request is pending.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles in a serve state without mem_ready before aborting.
REQ-003 clk  input  1  clock; all state is updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  1  instruction fetch request; held high until i_valid.
REQ-006 i_addr  input  32  fetch address.
REQ-007 d_cmd  input  2  data command: BUS_NONE, BUS_LOAD or BUS_STORE; held until d_valid.
REQ-008 d_addr  input  32  data address.
REQ-009 d_wdata  input  32  store data.
REQ-010 mem_rdata  input  32  shared memory read data.
REQ-011 mem_ready  input  1  memory completes the current access this cycle.
REQ-012 mem_cmd  output  2  command to the shared memory port.
REQ-013 mem_addr  output  32  address to the shared memory port.
REQ-014 mem_wdata  output  32  write data to the shared memory port.
REQ-015 i_valid, i_rdata, i_err  output  1/32/1  fetch completion, fetched word, and timeout flag.
REQ-016 d_valid, d_rdata, d_err  output  1/32/1  data completion, load word, and timeout flag.
REQ-017 i_stall, d_stall  output  1/1  requester pending and not completed this cycle.

Function
REQ-018 FSM states SHALL be IDLE, SERVE_I and SERVE_D.
REQ-019 Requests SHALL be sampled only in IDLE.
REQ-020 In IDLE, the grant SHALL go to data if d_cmd!=BUS_NONE, unless i_req=1 and streak==STREAK_MAX, in which case it goes to instruction.
REQ-021 In IDLE with only i_req=1, the grant SHALL go to instruction; with no request, the FSM stays in IDLE.
REQ-022 On a grant, address, command and wdata SHALL be latched into internal registers; mem_cmd/mem_addr/mem_wdata SHALL be driven from these registers during SERVE_x.
REQ-023 In IDLE, mem_cmd SHALL be BUS_NONE.
REQ-024 SERVE_I SHALL drive mem_cmd=BUS_LOAD.
REQ-025 SERVE_D SHALL drive the latched d_cmd.
REQ-026 In SERVE_x with mem_ready=1: x_valid SHALL be 1 in that same cycle (combinational); x_rdata=mem_rdata for loads and 0 for stores; next state IDLE.
REQ-027 Minimum latency SHALL be: request seen in IDLE at cycle N -> mem_cmd at N+1 -> earliest x_valid at N+1 -> IDLE at N+2, giving a one-cycle bubble between accesses.
REQ-028 streak SHALL be a 3-bit saturating counter: incremented on a data grant while i_req=1; cleared on any instruction grant or when i_req=0 at a data grant.
REQ-029 A wait counter SHALL clear on entry to a serve state and increment each serve cycle without mem_ready.
REQ-030 When the wait counter reaches TIMEOUT, the arbiter SHALL assert x_valid=1 with x_err=1 and x_rdata=0 for one cycle, then return to IDLE.
REQ-031 mem_ready in the same cycle as the timeout SHALL count as a normal completion with no error.
REQ-032 mem_ready while in IDLE SHALL be ignored.
REQ-033 i_stall SHALL equal i_req & ~i_valid; d_stall SHALL equal (d_cmd!=BUS_NONE) & ~d_valid.
REQ-034 If the requester drops its request mid-serve, the access SHALL still complete; the completion pulse is dropped by the requester.

Reset
REQ-035 rst SHALL immediately force: state IDLE; mem_cmd=BUS_NONE; mem_addr=0; mem_wdata=0; all valid/err outputs 0; rdata outputs 0; streak and wait counters 0.
REQ-036 Reset mid-serve SHALL abort the access with no completion pulse.

Structure
REQ-037 The BUS_NONE/BUS_LOAD/BUS_STORE encodings SHALL come from the shared sys_defs package.
REQ-038 An arb_state_t enum SHALL be added to sys_defs.
REQ-039 The block SHALL be a single module with no sub-modules.

Verification
REQ-040 i_req=1 at 0x100 alone, memory ready after 2 cycles -> mem_cmd=BUS_LOAD, mem_addr=0x100 for 2 cycles; i_valid=1 with i_rdata=mem_rdata on the 2nd cycle; IDLE next cycle.
REQ-041 i_req and d_cmd=BUS_LOAD asserted together -> data is served first, then instruction; i_stall=1 throughout the data access.
REQ-042 d_cmd held busy for 6 accesses with i_req=1 and 1-cycle memory -> the 5th grant goes to instruction (streak=4), then data resumes.
REQ-043 BUS_STORE at 0x20 with wdata 0xDEADBEEF -> mem_wdata=0xDEADBEEF; d_valid=1 with d_rdata=0.
REQ-044 Memory never ready -> d_valid=1 and d_err=1 after 15 serve cycles; next request is granted normally.
REQ-045 rst pulsed mid-SERVE_I -> mem_cmd=BUS_NONE in the same cycle; no i_valid; restart serves cleanly.

Source files
------------

// File: rtl/sys_defs.sv
// Shared system definitions: memory bus command encodings and the memory
// arbiter state type.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between an instruction fetch port and a
// data load/store port, with anti-starvation streak limit and access timeout.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [1:0]  d_cmd,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        i_stall,
  output logic        d_stall
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM   = WAIT_W'(TIMEOUT);
  localparam logic [2:0]        STREAK_LIM = 3'(STREAK_MAX);

  arb_state_t        state, state_next;
  logic [2:0]        streak;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cmd_q;
  logic [31:0]       addr_q, wdata_q;
  logic              grant_i, grant_d, done, timeout;
  logic [31:0]       rdata;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    rdata      = '0;
    mem_cmd    = BUS_NONE;
    i_valid    = 1'b0;
    i_rdata    = '0;
    i_err      = 1'b0;
    d_valid    = 1'b0;
    d_rdata    = '0;
    d_err      = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless it has starved a pending fetch for STREAK_MAX grants.
        if (d_cmd != BUS_NONE && !(i_req && streak == STREAK_LIM)) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        mem_cmd = cmd_q;
        timeout = (wait_cnt == WAIT_LIM);
        done    = mem_ready | timeout;
        rdata   = (mem_ready && cmd_q == BUS_LOAD) ? mem_rdata : '0;
        if (done) state_next = IDLE;
        if (state == SERVE_I) begin
          i_valid = done;
          i_rdata = rdata;
          i_err   = timeout & ~mem_ready;
        end else begin
          d_valid = done;
          d_rdata = rdata;
          d_err   = timeout & ~mem_ready;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_stall   = i_req & ~i_valid;
  assign d_stall   = (d_cmd != BUS_NONE) & ~d_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q    <= BUS_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      streak   <= '0;
      wait_cnt <= '0;
    end else begin
      if (grant_i) begin
        cmd_q   <= BUS_LOAD;
        addr_q  <= i_addr;
        wdata_q <= '0;
        streak  <= '0;
      end
      if (grant_d) begin
        cmd_q   <= d_cmd;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        if (!i_req)               streak <= '0;
        else if (streak != 3'h7)  streak <= streak + 3'd1;
      end
      if (grant_i || grant_d)             wait_cnt <= '0;
      else if (state != IDLE && !done)    wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, priority, streak
// limit, stores, timeout, and reset behaviour with hand-computed expectations.
module tb_mem_arbiter;
  import sys_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [1:0]  d_cmd;
  logic [31:0] d_addr, d_wdata, mem_rdata;
  logic        mem_ready;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr, mem_wdata;
  logic        i_valid, i_err, d_valid, d_err, i_stall, d_stall;
  logic [31:0] i_rdata, d_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STREAK_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_cmd(d_cmd), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_valid(i_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .i_stall(i_stall), .d_stall(d_stall)
  );

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0; d_cmd = BUS_NONE; d_addr = '0;
    d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_req = 1'b1;
    rst = 1'b1;
    #3;
    checks++;
    if ({mem_cmd, mem_addr, mem_wdata, i_valid, i_rdata, i_err, d_valid, d_rdata, d_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h addr=%h wdata=%h iv=%b ir=%h ie=%b dv=%b dr=%h de=%b, want all zero",
               mem_cmd, mem_addr, mem_wdata, i_valid, i_rdata, i_err, d_valid, d_rdata, d_err);
    end
    checks++;
    if (i_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_i_stall: got %b want 1", i_stall);
    end
    next_cycle();
    checks++;
    if ({mem_cmd, i_valid} !== {BUS_NONE, 1'b0}) begin
      errors++;
      $display("FAIL reset_held: got cmd=%h iv=%b want cmd=0 iv=0", mem_cmd, i_valid);
    end
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    next_cycle();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({mem_cmd, i_stall} !== {BUS_NONE, 1'b1}) begin
      errors++;
      $display("FAIL fetch_idle: got cmd=%h stall=%b want cmd=0 stall=1", mem_cmd, i_stall);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_cmd, mem_addr, i_valid} !== {BUS_LOAD, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL fetch_wait: got cmd=%h addr=%h iv=%b want cmd=1 addr=100 iv=0", mem_cmd, mem_addr, i_valid);
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    checks++;
    if ({mem_cmd, mem_addr, i_valid, i_rdata, i_err, i_stall} !== {BUS_LOAD, 32'h100, 1'b1, 32'hCAFE0001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_done: got cmd=%h addr=%h iv=%b ir=%h ie=%b st=%b want 1 100 1 cafe0001 0 0",
               mem_cmd, mem_addr, i_valid, i_rdata, i_err, i_stall);
    end
    next_cycle();
    i_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_cmd, i_valid} !== {BUS_NONE, 1'b0}) begin
      errors++;
      $display("FAIL fetch_back_idle: got cmd=%h iv=%b want 0 0", mem_cmd, i_valid);
    end
  endtask

  task automatic test_priority();
    next_cycle();
    i_req = 1'b1; i_addr = 32'h200; d_cmd = BUS_LOAD; d_addr = 32'h40;
    @(negedge clk);
    checks++;
    if ({mem_cmd, i_stall, d_stall} !== {BUS_NONE, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL prio_idle: got cmd=%h is=%b ds=%b want 0 1 1", mem_cmd, i_stall, d_stall);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_cmd, mem_addr, i_stall, d_stall} !== {BUS_LOAD, 32'h40, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL prio_data_first: got cmd=%h addr=%h is=%b ds=%b want 1 40 1 1", mem_cmd, mem_addr, i_stall, d_stall);
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h11112222;
    @(negedge clk);
    checks++;
    if ({d_valid, d_rdata, d_err, d_stall, i_valid, i_stall} !== {1'b1, 32'h11112222, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL prio_data_done: got dv=%b dr=%h de=%b ds=%b iv=%b is=%b want 1 11112222 0 0 0 1",
               d_valid, d_rdata, d_err, d_stall, i_valid, i_stall);
    end
    next_cycle();
    d_cmd = BUS_NONE; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_cmd, i_stall} !== {BUS_NONE, 1'b1}) begin
      errors++;
      $display("FAIL prio_bubble: got cmd=%h is=%b want 0 1", mem_cmd, i_stall);
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h33334444;
    @(negedge clk);
    checks++;
    if ({mem_cmd, mem_addr, i_valid, i_rdata} !== {BUS_LOAD, 32'h200, 1'b1, 32'h33334444}) begin
      errors++;
      $display("FAIL prio_instr_next: got cmd=%h addr=%h iv=%b ir=%h want 1 200 1 33334444", mem_cmd, mem_addr, i_valid, i_rdata);
    end
    next_cycle();
    i_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streak();
    logic [31:0] exp_addr;
    logic        exp_i;
    next_cycle();
    i_req = 1'b1; i_addr = 32'h300; d_cmd = BUS_LOAD; mem_ready = 1'b1; mem_rdata = 32'h77;
    for (int k = 0; k < 7; k++) begin
      d_addr   = 32'h400 + 32'(k * 4);
      exp_i    = (k == 4);
      exp_addr = exp_i ? 32'h300 : d_addr;
      @(negedge clk);
      next_cycle(); @(negedge clk);
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL streak_addr[%0d]: got %h want %h", k, mem_addr, exp_addr);
      end
      checks++;
      if ({i_valid, d_valid} !== {exp_i, ~exp_i}) begin
        errors++;
        $display("FAIL streak_grant[%0d]: got iv=%b dv=%b want iv=%b dv=%b", k, i_valid, d_valid, exp_i, ~exp_i);
      end
      next_cycle();
      if (k == 4) i_req = 1'b0;
    end
    d_cmd = BUS_NONE; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    next_cycle();
    d_cmd = BUS_STORE; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; mem_rdata = 32'h55555555;
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_cmd, mem_addr, mem_wdata, d_valid} !== {BUS_STORE, 32'h20, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL store_drive: got cmd=%h addr=%h wdata=%h dv=%b want 2 20 deadbeef 0", mem_cmd, mem_addr, mem_wdata, d_valid);
    end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_valid, d_rdata, d_err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL store_done: got dv=%b dr=%h de=%b want 1 0 0", d_valid, d_rdata, d_err);
    end
    next_cycle();
    d_cmd = BUS_NONE; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    next_cycle();
    d_cmd = BUS_LOAD; d_addr = 32'h80; mem_rdata = 32'h9999AAAA; mem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      next_cycle(); @(negedge clk);
      if (d_valid) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d valid cycles in first 15 serve cycles want 0", early);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({d_valid, d_err, d_rdata, mem_cmd} !== {1'b1, 1'b1, 32'h0, BUS_LOAD}) begin
      errors++;
      $display("FAIL timeout_abort: got dv=%b de=%b dr=%h cmd=%h want 1 1 0 1", d_valid, d_err, d_rdata, mem_cmd);
    end
    next_cycle();
    d_addr = 32'h84; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_cmd, d_valid} !== {BUS_NONE, 1'b0}) begin
      errors++;
      $display("FAIL idle_ready_ignored: got cmd=%h dv=%b want 0 0", mem_cmd, d_valid);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_addr, d_valid, d_err, d_rdata} !== {32'h84, 1'b1, 1'b0, 32'h9999AAAA}) begin
      errors++;
      $display("FAIL timeout_recover: got addr=%h dv=%b de=%b dr=%h want 84 1 0 9999aaaa", mem_addr, d_valid, d_err, d_rdata);
    end
    next_cycle();
    d_cmd = BUS_NONE; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout_ready();
    next_cycle();
    i_req = 1'b1; i_addr = 32'h600; mem_rdata = 32'hABCD0123; mem_ready = 1'b0;
    repeat (16) next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_valid, i_err, i_rdata} !== {1'b1, 1'b0, 32'hABCD0123}) begin
      errors++;
      $display("FAIL timeout_with_ready: got iv=%b ie=%b ir=%h want 1 0 abcd0123", i_valid, i_err, i_rdata);
    end
    next_cycle();
    i_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    next_cycle();
    i_req = 1'b1; i_addr = 32'h500; mem_ready = 1'b0;
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_cmd, mem_addr} !== {BUS_LOAD, 32'h500}) begin
      errors++;
      $display("FAIL rstmid_serving: got cmd=%h addr=%h want 1 500", mem_cmd, mem_addr);
    end
    #2;
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1234;
    #1;
    checks++;
    if ({mem_cmd, mem_addr, i_valid, i_err, i_rdata} !== {BUS_NONE, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_abort: got cmd=%h addr=%h iv=%b ie=%b ir=%h want all zero", mem_cmd, mem_addr, i_valid, i_err, i_rdata);
    end
    next_cycle();
    checks++;
    if ({mem_cmd, i_valid} !== {BUS_NONE, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_held: got cmd=%h iv=%b want 0 0", mem_cmd, i_valid);
    end
    rst = 1'b0; mem_ready = 1'b0;
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_cmd, mem_addr, i_valid} !== {BUS_LOAD, 32'h500, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_restart: got cmd=%h addr=%h iv=%b want 1 500 0", mem_cmd, mem_addr, i_valid);
    end
    next_cycle();
    mem_ready = 1'b1; mem_rdata = 32'h5A5A0F0F;
    @(negedge clk);
    checks++;
    if ({i_valid, i_rdata, i_err} !== {1'b1, 32'h5A5A0F0F, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_complete: got iv=%b ir=%h ie=%b want 1 5a5a0f0f 0", i_valid, i_rdata, i_err);
    end
    next_cycle();
    i_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_streak();
    test_store();
    test_timeout();
    test_timeout_ready();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
